traffic_phase_scheduler: RTL and testbench

//   Demand-actuated phase scheduler for a two-approach intersection with a pedestrian phase.

---
 rtl/traffic_phase_scheduler_if.sv | 29 ++
 rtl/traffic_phase_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// Handshake bundle for traffic_phase_scheduler: detector/button inputs and lamp/status outputs.
// The controller side uses the slave modport; the field side (detectors, lamps) uses master.
interface traffic_phase_scheduler_if #(
   parameter int CNT_W = 8
);
   logic             veh_req1;
   logic             veh_req2;
   logic             ped_req;
   logic             red1;
   logic             yellow1;
   logic             green1;
   logic             red2;
   logic             yellow2;
   logic             green2;
   logic             walk;
   logic             ped_ack;
   logic [2:0]       phase;
   logic [CNT_W-1:0] remaining;

   modport master (
      output veh_req1, veh_req2, ped_req,
      input  red1, yellow1, green1, red2, yellow2, green2, walk, ped_ack, phase, remaining
   );

   modport slave (
      input  veh_req1, veh_req2, ped_req,
      output red1, yellow1, green1, red2, yellow2, green2, walk, ped_ack, phase, remaining
   );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated two-approach intersection scheduler with pedestrian walk phase.
// Optional macro FLASH_MODE_EN adds a 'flash' input for flashing-yellow operation.
module traffic_phase_scheduler #(
   parameter int TICK_DIV    = 1024,
   parameter int MIN_GREEN   = 10,
   parameter int MAX_GREEN   = 60,
   parameter int EXT_TIME    = 3,
   parameter int YELLOW_TIME = 3,
   parameter int ALLRED_TIME = 2,
   parameter int PED_TIME    = 8,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic reset,
`ifdef FLASH_MODE_EN
   input  logic flash,
`endif
   traffic_phase_scheduler_if.slave bus
);

   localparam int               PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MAX_G   = CNT_W'(MAX_GREEN);
   localparam logic [CNT_W-1:0] EXT_T   = CNT_W'(EXT_TIME);
   localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW_TIME);
   localparam logic [CNT_W-1:0] AR_T    = CNT_W'(ALLRED_TIME);
   localparam logic [CNT_W-1:0] PED_T   = CNT_W'(PED_TIME);

   // Lamp vector layout: {red1, yellow1, green1, red2, yellow2, green2, walk}
   localparam logic [6:0] L_RED = 7'b100_100_0;
   localparam logic [6:0] L_G1  = 7'b001_100_0;
   localparam logic [6:0] L_Y1  = 7'b010_100_0;
   localparam logic [6:0] L_G2  = 7'b100_001_0;
   localparam logic [6:0] L_Y2  = 7'b100_010_0;
   localparam logic [6:0] L_PED = 7'b100_100_1;

   typedef enum logic [2:0] {
      STARTUP = 3'd0,
      G1      = 3'd1,
      Y1      = 3'd2,
      AR1     = 3'd3,
      G2      = 3'd4,
      Y2      = 3'd5,
      AR2     = 3'd6,
      PED     = 3'd7
   } state_t;

   state_t           state;
   state_t           nxt;
   logic             go;
   logic             run;
   logic             tick;
   logic [PS_W-1:0]  prescaler;
   logic             ped_pend;
   logic [1:0]       next_dir;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] elapsed;
   logic [CNT_W-1:0] gap;
   logic [CNT_W-1:0] el_eff;
   logic [CNT_W-1:0] gap_eff;
   logic             own_veh;
   logic             opp_veh;
   logic             demand;
   logic [6:0]       lamps;
   logic             ped_ack;
`ifdef FLASH_MODE_EN
   logic             flash_q;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

   function automatic logic [6:0] lamp_of(input state_t s);
      case (s)
         G1:      return L_G1;
         Y1:      return L_Y1;
         G2:      return L_G2;
         Y2:      return L_Y2;
         PED:     return L_PED;
         default: return L_RED;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] interval_of(input state_t s);
      case (s)
         Y1, Y2:           return YEL_T;
         AR1, AR2, STARTUP: return AR_T;
         PED:              return PED_T;
         default:          return '0;
      endcase
   endfunction

   always_comb begin
      tick    = (prescaler == PS_LAST);
      own_veh = (state == G2) ? bus.veh_req2 : bus.veh_req1;
      opp_veh = (state == G2) ? bus.veh_req1 : bus.veh_req2;
      demand  = opp_veh | ped_pend;
      el_eff  = tick ? sat_inc(elapsed, MAX_G) : elapsed;
      // A detector hit on the tick cycle itself still restarts the gap.
      gap_eff = own_veh ? '0 : (tick ? sat_inc(gap, EXT_T) : gap);
`ifdef FLASH_MODE_EN
      run     = !(flash | flash_q);
`else
      run     = 1'b1;
`endif
      go  = 1'b0;
      nxt = state;
      case (state)
         STARTUP: if (tick && remaining == ONE) begin
            go  = 1'b1;
            nxt = (next_dir == 2'd2) ? G2 : G1;
         end
         G1, G2: if (tick && demand &&
                     (el_eff >= MAX_G || (el_eff >= MIN_G && gap_eff >= EXT_T))) begin
            go  = 1'b1;
            nxt = (state == G1) ? Y1 : Y2;
         end
         Y1: if (tick && remaining == ONE) begin
            go  = 1'b1;
            nxt = AR1;
         end
         Y2: if (tick && remaining == ONE) begin
            go  = 1'b1;
            nxt = AR2;
         end
         AR1: if (tick && remaining == ONE) begin
            go  = 1'b1;
            nxt = ped_pend ? PED : G2;
         end
         AR2: if (tick && remaining == ONE) begin
            go  = 1'b1;
            nxt = ped_pend ? PED : G1;
         end
         PED: if (tick && remaining == ONE) begin
            go  = 1'b1;
            nxt = (next_dir == 2'd2) ? G2 : G1;
         end
         default: begin
            go  = 1'b1;
            nxt = STARTUP;
         end
      endcase
      go = go & run;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= STARTUP;
         lamps     <= L_RED;
         ped_ack   <= 1'b0;
         ped_pend  <= 1'b0;
         prescaler <= '0;
         next_dir  <= 2'd1;
         remaining <= AR_T;
         elapsed   <= '0;
         gap       <= '0;
`ifdef FLASH_MODE_EN
         flash_q   <= 1'b0;
`endif
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         ped_ack   <= 1'b0;
         // A press landing on the PED entry cycle must survive for the next cycle round.
         if (bus.ped_req)
            ped_pend <= 1'b1;
         else if (go && nxt == PED)
            ped_pend <= 1'b0;
`ifdef FLASH_MODE_EN
         flash_q <= flash;
         if (flash) begin
            state <= STARTUP;
            if (!flash_q || tick)
               lamps <= {1'b0, !flash_q | ~lamps[5], 1'b0, 1'b0, !flash_q | ~lamps[5], 1'b0, 1'b0};
         end else if (flash_q) begin
            state     <= STARTUP;
            lamps     <= L_RED;
            remaining <= AR_T;
            elapsed   <= '0;
            gap       <= '0;
         end else
`endif
         if (go) begin
            state     <= nxt;
            lamps     <= lamp_of(nxt);
            remaining <= interval_of(nxt);
            elapsed   <= '0;
            gap       <= '0;
            if (nxt == PED) begin
               ped_ack  <= 1'b1;
               next_dir <= (state == AR1) ? 2'd2 : 2'd1;
            end
         end else if (state == G1 || state == G2) begin
            elapsed <= el_eff;
            gap     <= gap_eff;
         end else if (tick) begin
            remaining <= remaining - 1'b1;
         end
      end
   end

   assign bus.red1      = lamps[6];
   assign bus.yellow1   = lamps[5];
   assign bus.green1    = lamps[4];
   assign bus.red2      = lamps[3];
   assign bus.yellow2   = lamps[2];
   assign bus.green2    = lamps[1];
   assign bus.walk      = lamps[0];
   assign bus.ped_ack   = ped_ack;
   assign bus.phase     = state;
   assign bus.remaining = remaining;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a 4-clk tick and short phase times.
// Cycle index cyc counts falling edges since reset release; posedge k precedes negedge k.
module tb_traffic_phase_scheduler;
   localparam int CNT_W = 8;
   localparam logic [6:0] L_RED = 7'b100_100_0;
   localparam logic [6:0] L_G1  = 7'b001_100_0;
   localparam logic [6:0] L_Y1  = 7'b010_100_0;
   localparam logic [6:0] L_G2  = 7'b100_001_0;
   localparam logic [6:0] L_Y2  = 7'b100_010_0;
   localparam logic [6:0] L_PED = 7'b100_100_1;

   logic clk = 1'b0;
   logic reset = 1'b1;
`ifdef FLASH_MODE_EN
   logic flash = 1'b0;
`endif
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic [6:0] lamps_obs;

   traffic_phase_scheduler_if #(.CNT_W(CNT_W)) bus ();

   traffic_phase_scheduler #(
      .TICK_DIV(4), .MIN_GREEN(4), .MAX_GREEN(8), .EXT_TIME(2),
      .YELLOW_TIME(2), .ALLRED_TIME(1), .PED_TIME(3), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef FLASH_MODE_EN
      .flash(flash),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign lamps_obs = {bus.red1, bus.yellow1, bus.green1, bus.red2, bus.yellow2, bus.green2, bus.walk};

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic goto(input int k);
      if (k > cyc) step(k - cyc);
   endtask

   task automatic do_reset(input logic v1, input logic v2);
      @(negedge clk);
      reset = 1'b1;
      bus.veh_req1 = v1;
      bus.veh_req2 = v2;
      bus.ped_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset;
      bus.veh_req1 = 1'b0;
      bus.veh_req2 = 1'b0;
      bus.ped_req = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (lamps_obs !== L_RED) begin n_bad++; $display("FAIL reset_lamps got %b want %b", lamps_obs, L_RED); end
      n_cmp++;
      if (bus.phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
      n_cmp++;
      if (bus.ped_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ped_ack got %b want 0", bus.ped_ack); end
      n_cmp++;
      if (bus.remaining !== 8'd1) begin n_bad++; $display("FAIL reset_remaining got %0d want 1", bus.remaining); end
   endtask

   task automatic test_rest_in_green;
      logic bad;
      do_reset(1'b0, 1'b0);
      goto(3);
      n_cmp++;
      if (bus.phase !== 3'd0) begin n_bad++; $display("FAIL startup_hold phase got %0d want 0", bus.phase); end
      goto(4);
      n_cmp++;
      if (bus.phase !== 3'd1 || lamps_obs !== L_G1) begin
         n_bad++; $display("FAIL startup_exit phase/lamps got %0d/%b want 1/%b", bus.phase, lamps_obs, L_G1);
      end
      n_cmp++;
      if (bus.remaining !== 8'd0) begin n_bad++; $display("FAIL green_remaining got %0d want 0", bus.remaining); end
      bad = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (bus.phase !== 3'd1 || lamps_obs !== L_G1) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin n_bad++; $display("FAIL rest_in_g1 got phase %0d at end, want 1 throughout", bus.phase); end
   endtask

   task automatic test_gap_extension;
      do_reset(1'b0, 1'b1);
      goto(19);
      n_cmp++;
      if (bus.phase !== 3'd1) begin n_bad++; $display("FAIL gap_g1_hold phase got %0d want 1", bus.phase); end
      goto(20);
      n_cmp++;
      if (bus.phase !== 3'd2 || lamps_obs !== L_Y1 || bus.remaining !== 8'd2) begin
         n_bad++; $display("FAIL gap_y1_entry phase/lamps/rem got %0d/%b/%0d want 2/%b/2",
                           bus.phase, lamps_obs, bus.remaining, L_Y1);
      end
      goto(24);
      n_cmp++;
      if (bus.remaining !== 8'd1) begin n_bad++; $display("FAIL gap_y1_rem got %0d want 1", bus.remaining); end
      goto(27);
      n_cmp++;
      if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL gap_y1_len phase got %0d want 2", bus.phase); end
      goto(28);
      n_cmp++;
      if (bus.phase !== 3'd3 || lamps_obs !== L_RED || bus.remaining !== 8'd1) begin
         n_bad++; $display("FAIL gap_ar1 phase/lamps/rem got %0d/%b/%0d want 3/%b/1",
                           bus.phase, lamps_obs, bus.remaining, L_RED);
      end
      goto(32);
      n_cmp++;
      if (bus.phase !== 3'd4 || lamps_obs !== L_G2) begin
         n_bad++; $display("FAIL gap_g2_entry phase/lamps got %0d/%b want 4/%b", bus.phase, lamps_obs, L_G2);
      end
      goto(100);
      n_cmp++;
      if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL gap_g2_rest phase got %0d want 4", bus.phase); end
   endtask

   task automatic test_max_green_and_reset_mid_y2;
      do_reset(1'b1, 1'b1);
      goto(35);
      n_cmp++;
      if (bus.phase !== 3'd1) begin n_bad++; $display("FAIL max_g1_hold phase got %0d want 1", bus.phase); end
      goto(36);
      n_cmp++;
      if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL max_g1_exit phase got %0d want 2", bus.phase); end
      goto(48);
      n_cmp++;
      if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL max_g2_entry phase got %0d want 4", bus.phase); end
      goto(79);
      n_cmp++;
      if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL max_g2_hold phase got %0d want 4", bus.phase); end
      goto(80);
      n_cmp++;
      if (bus.phase !== 3'd5 || lamps_obs !== L_Y2) begin
         n_bad++; $display("FAIL max_y2_entry phase/lamps got %0d/%b want 5/%b", bus.phase, lamps_obs, L_Y2);
      end
      goto(81);
      bus.ped_req = 1'b1;
      goto(82);
      bus.ped_req = 1'b0;
      n_cmp++;
      if (bus.remaining !== 8'd2) begin n_bad++; $display("FAIL mid_y2_rem got %0d want 2", bus.remaining); end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (lamps_obs !== L_RED || bus.phase !== 3'd0 || bus.remaining !== 8'd1) begin
         n_bad++; $display("FAIL async_reset lamps/phase/rem got %b/%0d/%0d want %b/0/1",
                           lamps_obs, bus.phase, bus.remaining, L_RED);
      end
      bus.veh_req1 = 1'b0;
      bus.veh_req2 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      goto(4);
      n_cmp++;
      if (bus.phase !== 3'd1) begin n_bad++; $display("FAIL post_reset_g1 phase got %0d want 1", bus.phase); end
      goto(60);
      n_cmp++;
      if (bus.phase !== 3'd1) begin n_bad++; $display("FAIL ped_discarded phase got %0d want 1", bus.phase); end
   endtask

   task automatic test_ped_during_green;
      do_reset(1'b0, 1'b0);
      goto(5);
      bus.ped_req = 1'b1;
      goto(6);
      bus.ped_req = 1'b0;
      goto(20);
      n_cmp++;
      if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL ped_y1 phase got %0d want 2", bus.phase); end
      goto(31);
      n_cmp++;
      if (bus.phase !== 3'd3 || bus.walk !== 1'b0) begin
         n_bad++; $display("FAIL ped_ar1 phase/walk got %0d/%b want 3/0", bus.phase, bus.walk);
      end
      goto(32);
      n_cmp++;
      if (bus.phase !== 3'd7 || lamps_obs !== L_PED || bus.ped_ack !== 1'b1 || bus.remaining !== 8'd3) begin
         n_bad++; $display("FAIL ped_entry phase/lamps/ack/rem got %0d/%b/%b/%0d want 7/%b/1/3",
                           bus.phase, lamps_obs, bus.ped_ack, bus.remaining, L_PED);
      end
      goto(33);
      n_cmp++;
      if (bus.ped_ack !== 1'b0 || bus.walk !== 1'b1) begin
         n_bad++; $display("FAIL ped_ack_pulse ack/walk got %b/%b want 0/1", bus.ped_ack, bus.walk);
      end
      goto(43);
      n_cmp++;
      if (bus.phase !== 3'd7 || bus.walk !== 1'b1) begin
         n_bad++; $display("FAIL ped_len phase/walk got %0d/%b want 7/1", bus.phase, bus.walk);
      end
      goto(44);
      n_cmp++;
      if (bus.phase !== 3'd4 || lamps_obs !== L_G2) begin
         n_bad++; $display("FAIL ped_to_g2 phase/lamps got %0d/%b want 4/%b", bus.phase, lamps_obs, L_G2);
      end
      goto(100);
      n_cmp++;
      if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL ped_cleared phase got %0d want 4", bus.phase); end
   endtask

   task automatic test_ped_on_entry;
      do_reset(1'b0, 1'b0);
      goto(5);
      bus.ped_req = 1'b1;
      goto(6);
      bus.ped_req = 1'b0;
      goto(31);
      bus.ped_req = 1'b1;
      goto(32);
      bus.ped_req = 1'b0;
      n_cmp++;
      if (bus.phase !== 3'd7 || bus.ped_ack !== 1'b1) begin
         n_bad++; $display("FAIL reentry_first_ped phase/ack got %0d/%b want 7/1", bus.phase, bus.ped_ack);
      end
      goto(59);
      n_cmp++;
      if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL reentry_g2_hold phase got %0d want 4", bus.phase); end
      goto(60);
      n_cmp++;
      if (bus.phase !== 3'd5) begin n_bad++; $display("FAIL reentry_y2 phase got %0d want 5", bus.phase); end
      goto(68);
      n_cmp++;
      if (bus.phase !== 3'd6 || lamps_obs !== L_RED) begin
         n_bad++; $display("FAIL reentry_ar2 phase/lamps got %0d/%b want 6/%b", bus.phase, lamps_obs, L_RED);
      end
      goto(72);
      n_cmp++;
      if (bus.phase !== 3'd7 || lamps_obs !== L_PED || bus.ped_ack !== 1'b1) begin
         n_bad++; $display("FAIL reentry_second_ped phase/lamps/ack got %0d/%b/%b want 7/%b/1",
                           bus.phase, lamps_obs, bus.ped_ack, L_PED);
      end
      goto(84);
      n_cmp++;
      if (bus.phase !== 3'd1 || lamps_obs !== L_G1) begin
         n_bad++; $display("FAIL reentry_to_g1 phase/lamps got %0d/%b want 1/%b", bus.phase, lamps_obs, L_G1);
      end
   endtask

   initial begin
      test_reset();
      test_rest_in_green();
      test_gap_extension();
      test_max_green_and_reset_mid_y2();
      test_ped_during_green();
      test_ped_on_entry();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
